// File: rtl/imem_responder.sv
// Instruction-memory responder: serves one word fetch at a time after a fixed
// latency, with a preload write port that takes priority over new fetches.
module imem_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [1:0]  rsp_err,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends on ready, and payloads are held while valid.

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("imem_responder: LATENCY must be in 1..4");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("imem_responder: BASE_ADDR must be word aligned");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] instr_q, instr_d;
  logic [1:0]  err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic [31:0]      req_off, load_off;
  logic [1:0]       req_err, load_err;
  logic [IDX_W-1:0] req_idx, load_idx;

  // BASE_ADDR is word aligned, so the offset's low bits equal the address's.
  assign req_off  = req_addr - BASE_ADDR;
  assign load_off = load_addr - BASE_ADDR;
  assign req_idx  = req_off[IDX_W+1:2];
  assign load_idx = load_off[IDX_W+1:2];

  always_comb begin
    req_err = 2'b00;
    if (req_off[1:0] != 2'b00) begin
      req_err = 2'b01;
    end else if (req_addr < BASE_ADDR || {2'b00, req_off[31:2]} >= 32'(DEPTH)) begin
      req_err = 2'b10;
    end
  end

  always_comb begin
    load_err = 2'b00;
    if (load_off[1:0] != 2'b00) begin
      load_err = 2'b01;
    end else if (load_addr < BASE_ADDR || {2'b00, load_off[31:2]} >= 32'(DEPTH)) begin
      load_err = 2'b10;
    end
  end

  // Program image is deliberately not reset so it survives a core reset.
  always_ff @(posedge clk) begin
    if (load_en && load_err == 2'b00) begin
      mem[load_idx] <= load_data;
    end
  end

  assign req_ready = (state_q == S_IDLE) && !load_en;
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rsp_instr = instr_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          err_d   = req_err;
          instr_d = (req_err == 2'b00) ? mem[req_idx] : 32'h0;
          cnt_d   = 2'(LATENCY - 1);
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        // Leaving on the edge where the count reaches zero gives exactly
        // LATENCY edges from acceptance to rsp_valid.
        cnt_d = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      instr_q <= 32'h0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (LATENCY=1 at base 0, LATENCY=3 at
// base 0x100) share stimulus; a queue scoreboard checks every response.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic        rsp_ready = 1'b1;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = 32'h0;
  logic [31:0] load_data = 32'h0;
  int          cfg = 0;
  int          rdy_mode = 0;
  int          cyc = 0;

  logic        rr_a, rv_a, busy_a, rr_b, rv_b, busy_b;
  logic [31:0] ri_a, ri_b;
  logic [1:0]  re_a, re_b;
  logic        req_valid_a, req_valid_b;

  logic        rr_m, rv_m, busy_m;
  logic [31:0] ri_m;
  logic [1:0]  re_m;
  int          lat_m;

  logic [33:0] exp_q[$];
  int          acc_q[$];
  logic [31:0] ref_mem [logic [31:0]];

  int n_checks = 0;
  int n_fail = 0;

  assign req_valid_a = req_valid && (cfg == 0);
  assign req_valid_b = req_valid && (cfg == 1);
  assign rr_m   = (cfg == 1) ? rr_b : rr_a;
  assign rv_m   = (cfg == 1) ? rv_b : rv_a;
  assign busy_m = (cfg == 1) ? busy_b : busy_a;
  assign ri_m   = (cfg == 1) ? ri_b : ri_a;
  assign re_m   = (cfg == 1) ? re_b : re_a;
  assign lat_m  = (cfg == 1) ? 3 : 1;

  imem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .LATENCY(1)) u_dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid_a), .req_ready(rr_a),
    .req_addr(req_addr), .rsp_valid(rv_a), .rsp_ready(rsp_ready),
    .rsp_instr(ri_a), .rsp_err(re_a), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .busy(busy_a)
  );

  imem_responder #(.DEPTH(256), .BASE_ADDR(32'h0000_0100), .LATENCY(3)) u_dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(rr_b),
    .req_addr(req_addr), .rsp_valid(rv_b), .rsp_ready(rsp_ready),
    .rsp_instr(ri_b), .rsp_err(re_b), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .busy(busy_b)
  );

  // Clock / cycle counter / response-ready driver
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: rsp_ready = 1'b1;
        1: rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: {err, instr} for a fetch under the active configuration.
  function automatic logic [33:0] model_rsp(input logic [31:0] addr);
    longint base  = (cfg == 1) ? 64'h100 : 64'h0;
    longint depth = (cfg == 1) ? 256 : 1024;
    longint off   = longint'(addr) - base;
    if (addr % 4 != 0) return {2'b01, 32'h0};
    if (off < 0 || off / 4 >= depth) return {2'b10, 32'h0};
    if (!ref_mem.exists(addr)) return {2'b11, 32'hDEAD_DEAD};
    return {2'b00, ref_mem[addr]};
  endfunction

  // Driver tasks: entered and left at posedge + #1
  task automatic load(input logic [31:0] addr, input logic [31:0] data);
    load_en = 1'b1;
    load_addr = addr;
    load_data = data;
    @(posedge clk);
    #1;
    load_en = 1'b0;
    if (addr % 4 == 0) ref_mem[addr] = data;
  endtask

  task automatic fetch(input logic [31:0] addr);
    int  n = 0;
    bit  done = 0;
    req_valid = 1'b1;
    req_addr = addr;
    while (!done) begin
      @(negedge clk);
      if (rr_m) begin
        exp_q.push_back(model_rsp(addr));
        acc_q.push_back(cyc + 1);
        done = 1;
      end else if (++n > 200) begin
        check(1'b0, "req_accept_timeout", 64'(n), 64'(200));
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    req_addr = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) check(1'b0, "drain_timeout", 64'(exp_q.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int k = $urandom_range(0, 9);
    logic [8:0] w = 9'($urandom_range(0, 511));
    logic [1:0] lo = 2'($urandom_range(1, 3));
    if (k < 6) return {21'h0, w, 2'b00};
    if (k == 6) return {21'h0, w, lo};
    if (k == 7) return 32'h1000 + 32'($urandom_range(0, 15)) * 4;
    if (k == 8) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    return 32'($urandom_range(0, 63)) * 4;
  endfunction

  // Scoreboard monitor: compares whenever the selected DUT presents a response
  initial begin
    bit seen_valid = 0;
    bit idle_chk = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        seen_valid = 0;
        idle_chk = 0;
      end else begin
        if (idle_chk) begin
          idle_chk = 0;
          check(busy_m === 1'b0 && rv_m === 1'b0, "idle_after_hs",
                64'({busy_m, rv_m}), 64'(0));
          if (!load_en) check(rr_m === 1'b1, "ready_after_hs", 64'(rr_m), 64'(1));
        end
        if (rv_m === 1'b1) begin
          check(exp_q.size() != 0, "unexpected_rsp", 64'({re_m, ri_m}), 64'(0));
          if (exp_q.size() != 0) begin
            if (!seen_valid)
              check(cyc == acc_q[0] + lat_m - 1, "rsp_latency",
                    64'(cyc - acc_q[0] + 1), 64'(lat_m));
            seen_valid = 1;
            check({re_m, ri_m} === exp_q[0], "rsp_data", 64'({re_m, ri_m}), 64'(exp_q[0]));
            if (rsp_ready) begin
              void'(exp_q.pop_front());
              void'(acc_q.pop_front());
              seen_valid = 0;
              idle_chk = 1;
            end
          end
        end
      end
    end
  end

  // Directed and random stimulus
  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check({rv_a, busy_a, rr_a} === 3'b001, "reset_ctrl_a", 64'({rv_a, busy_a, rr_a}), 64'(1));
    check({re_a, ri_a} === 34'h0, "reset_data_a", 64'({re_a, ri_a}), 64'(0));
    check({rv_b, busy_b, rr_b} === 3'b001, "reset_ctrl_b", 64'({rv_b, busy_b, rr_b}), 64'(1));
    check({re_b, ri_b} === 34'h0, "reset_data_b", 64'({re_b, ri_b}), 64'(0));
    @(posedge clk);
    #1;

    for (int i = 0; i < 512; i++) load(32'(i * 4), $urandom);
    load(32'h0, 32'h1000_0093);
    load(32'h4, 32'h0020_0113);
    load(32'h104, 32'h0020_0113);

    // LATENCY=1, rsp_ready high: back-to-back fetches
    cfg = 0;
    rdy_mode = 0;
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h2);
    fetch(32'h1000);
    fetch(32'hFFFF_FFFC);
    drain();

    // Load and fetch together in IDLE: load wins, fetch sees the new word
    req_valid = 1'b1;
    req_addr = 32'h8;
    load_en = 1'b1;
    load_addr = 32'h8;
    load_data = 32'hCAFE_0001;
    @(negedge clk);
    check(rr_m === 1'b0, "load_blocks_req", 64'(rr_m), 64'(0));
    @(posedge clk);
    #1;
    load_en = 1'b0;
    ref_mem[32'h8] = 32'hCAFE_0001;
    @(negedge clk);
    check(rr_m === 1'b1, "req_after_load", 64'(rr_m), 64'(1));
    exp_q.push_back(model_rsp(32'h8));
    acc_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    drain();

    // LATENCY=3 with rsp_ready held low: response must stay stable
    cfg = 1;
    rdy_mode = 2;
    fetch(32'h104);
    begin
      int n = 0;
      while (rv_m !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check(rv_m === 1'b1, "hold_rsp_seen", 64'(rv_m), 64'(1));
      repeat (5) @(negedge clk);
    end
    @(posedge clk);
    #1;
    rdy_mode = 0;
    rsp_ready = 1'b1;
    drain();

    fetch(32'h0FE);
    fetch(32'h0FC);
    fetch(32'h500);
    fetch(32'h4FC);
    drain();

    // Preload while the fetch is in WAIT: response carries the old word
    fetch(32'h108);
    load(32'h108, 32'hBEEF_0108);
    fetch(32'h108);
    drain();

    // Reset during WAIT drops the pending response
    fetch(32'h10C);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    check({rv_m, busy_m, rr_m} === 3'b001, "reset_in_wait", 64'({rv_m, busy_m, rr_m}), 64'(1));
    repeat (5) @(posedge clk);
    #1;
    fetch(32'h10C);
    drain();

    // Random traffic on both configurations with random back-pressure
    for (int c = 0; c < 2; c++) begin
      cfg = c;
      rdy_mode = 1;
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 9) < 2) load(rand_addr(), $urandom);
        else fetch(rand_addr());
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      drain();
      rdy_mode = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule
